// File: rtl/seq_controller.sv
// Fetch/execute sequencer for the 9-bit CPU: owns pc, instruction register,
// data-memory handshake and a small call/return stack.
module seq_controller #(
  parameter int PC_W   = 10,
  parameter int STK_D  = 4,
  parameter int MEM_TO = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [8:0]      instr_i,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_en,
  output logic [8:0]      instr_q,
  input  logic            done_i,
  input  logic            mem_req_i,
  input  logic            mem_ack,
  output logic            mem_go,
  input  logic            br_take,
  input  logic [PC_W-1:0] br_target,
  input  logic            call_i,
  input  logic            ret_i,
  output logic            running,
  output logic            halted,
  output logic [1:0]      err
);

  localparam int SP_W = $clog2(STK_D + 1);
  localparam int SI_W = (STK_D > 1) ? $clog2(STK_D) : 1;
  localparam int TO_W = $clog2(MEM_TO + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEMW  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [1:0] E_OVF = 2'd1;
  localparam logic [1:0] E_UNF = 2'd2;
  localparam logic [1:0] E_TMO = 2'd3;

  logic [2:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [8:0]      r_instr;
  logic [SP_W-1:0] r_sp;
  logic [1:0]      r_err;
  logic [TO_W-1:0] r_tcnt;
  logic [PC_W-1:0] r_stk [STK_D];

  logic [PC_W-1:0] w_pc_inc;
  logic [TO_W-1:0] w_tnext;
  logic            w_stk_full;
  logic            w_stk_empty;
  logic [SI_W-1:0] w_push_idx;
  logic [SI_W-1:0] w_pop_idx;

  // pc+1 wraps naturally at PC_W bits; the wrapped value is what gets pushed
  assign w_pc_inc    = r_pc + 1'b1;
  assign w_tnext     = r_tcnt + 1'b1;
  assign w_stk_full  = (r_sp == SP_W'(STK_D));
  assign w_stk_empty = (r_sp == '0);
  assign w_push_idx  = SI_W'(r_sp);
  assign w_pop_idx   = SI_W'(r_sp - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_sp    <= '0;
      r_err   <= '0;
      r_tcnt  <= '0;
      for (int i = 0; i < STK_D; i++) r_stk[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc    <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_instr <= instr_i;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          // call outranks ret and consumes br_target itself
          if (done_i) begin
            r_state <= S_HALT;
          end else if (mem_req_i) begin
            r_tcnt  <= '0;
            r_state <= S_MEMW;
          end else if (call_i) begin
            if (w_stk_full) begin
              r_err   <= E_OVF;
              r_state <= S_HALT;
            end else begin
              r_stk[w_push_idx] <= w_pc_inc;
              r_sp              <= r_sp + 1'b1;
              r_pc              <= br_target;
              r_state           <= S_FETCH;
            end
          end else if (ret_i) begin
            if (w_stk_empty) begin
              r_err   <= E_UNF;
              r_state <= S_HALT;
            end else begin
              r_sp    <= r_sp - 1'b1;
              r_pc    <= r_stk[w_pop_idx];
              r_state <= S_FETCH;
            end
          end else if (br_take) begin
            r_pc    <= br_target;
            r_state <= S_FETCH;
          end else begin
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end
        end
        S_MEMW: begin
          // an ack on the final allowed cycle still counts as success
          if (mem_ack) begin
            r_pc    <= w_pc_inc;
            r_tcnt  <= '0;
            r_state <= S_FETCH;
          end else if (w_tnext == TO_W'(MEM_TO)) begin
            r_err   <= E_TMO;
            r_tcnt  <= '0;
            r_state <= S_HALT;
          end else begin
            r_tcnt <= w_tnext;
          end
        end
        S_HALT: begin
          if (start) begin
            r_err   <= '0;
            r_sp    <= '0;
            r_pc    <= '0;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // state-decoded outputs so an async reset drops mem_go immediately
  assign imem_addr = r_pc;
  assign imem_en   = (r_state == S_FETCH);
  assign instr_q   = r_instr;
  assign mem_go    = (r_state == S_MEMW);
  assign running   = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_MEMW);
  assign halted    = (r_state == S_HALT);
  assign err       = r_err;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: a tiny ROM plus decoder model drives the
// DUT, and a queue of expected fetch addresses is checked on every FETCH cycle.
module tb_seq_controller;

  localparam int PC_W   = 10;
  localparam int STK_D  = 4;
  localparam int MEM_TO = 15;

  localparam logic [8:0] NOP  = 9'h000;
  localparam logic [8:0] LD   = 9'h040;
  localparam logic [8:0] CALL = 9'h080;
  localparam logic [8:0] RET  = 9'h0C0;
  localparam logic [8:0] HLT  = 9'h140;
  localparam logic [8:0] JMAX = 9'h180;

  logic            clk = 1'b0;
  logic            reset, start, mem_ack;
  logic [8:0]      instr_i, instr_q;
  logic [PC_W-1:0] imem_addr, br_target, tgt;
  logic            imem_en, done_i, mem_req_i, mem_go, br_take, call_i, ret_i;
  logic            running, halted;
  logic [1:0]      err;
  logic [2:0]      op;

  logic [8:0] rom [0:1023];
  int npass = 0;
  int ntot  = 0;
  int go_cnt = 0;
  int unsigned exp_q[$];

  seq_controller #(.PC_W(PC_W), .STK_D(STK_D), .MEM_TO(MEM_TO)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_i(instr_i),
    .imem_addr(imem_addr), .imem_en(imem_en), .instr_q(instr_q),
    .done_i(done_i), .mem_req_i(mem_req_i), .mem_ack(mem_ack), .mem_go(mem_go),
    .br_take(br_take), .br_target(br_target), .call_i(call_i), .ret_i(ret_i),
    .running(running), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // decoder model: opcode in instr_q[8:6]
  assign instr_i   = rom[imem_addr];
  assign op        = instr_q[8:6];
  assign done_i    = (op == 3'd5);
  assign mem_req_i = (op == 3'd1);
  assign call_i    = (op == 3'd2);
  assign ret_i     = (op == 3'd3);
  assign br_take   = (op == 3'd4) || (op == 3'd6);
  assign br_target = (op == 3'd6) ? '1 : tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_go) go_cnt++;
    if (!reset && imem_en) begin
      if (exp_q.size() == 0) begin
        ntot++;
        $display("FAIL fetch_extra: observed addr %0d, expected no fetch", imem_addr);
      end else begin
        chk("fetch_addr", 32'(imem_addr), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = NOP;
  endtask

  task automatic restart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int bound);
    int n = 0;
    while (!halted && n < bound) begin tick(); n++; end
    chk(tag, 32'(halted), 32'd1);
  endtask

  task automatic wait_go(input string tag, input int bound);
    int n = 0;
    while (!mem_go && n < bound) begin tick(); n++; end
    chk(tag, 32'(mem_go), 32'd1);
  endtask

  task automatic wait_fetch(input string tag, input int addr, input int bound);
    int n = 0;
    while (!(imem_en && imem_addr == PC_W'(addr)) && n < bound) begin tick(); n++; end
    chk(tag, 32'(imem_addr), 32'(addr));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; tgt = '0;
    clear_rom();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_running", 32'(running), 0);
    chk("rst_halted",  32'(halted), 0);
    chk("rst_mem_go",  32'(mem_go), 0);
    chk("rst_imem_en", 32'(imem_en), 0);
    chk("rst_err",     32'(err), 0);
    chk("rst_pc",      32'(imem_addr), 0);
    chk("rst_instr_q", 32'(instr_q), 0);
    reset = 1'b0;
    tick();

    // straight-line code, then a load with ack on the third MEMW cycle
    rom[5] = LD; rom[6] = HLT;
    for (int i = 0; i <= 6; i++) exp_q.push_back(i);
    go_cnt = 0;
    restart();
    chk("a_fetch0_en", 32'(imem_en), 1);
    chk("a_running",   32'(running), 1);
    tick();
    chk("a_exec_en",   32'(imem_en), 0);
    chk("a_exec_run",  32'(running), 1);
    tick();
    chk("a_fetch1_en", 32'(imem_en), 1);
    wait_go("a_go_seen", 40);
    repeat (2) tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("a_go_cycles", 32'(go_cnt), 3);
    chk("a_go_low",    32'(mem_go), 0);
    chk("a_after_ld",  32'(imem_addr), 6);
    wait_halt("a_halt", 20);
    chk("a_err",       32'(err), 0);
    chk("a_pc_hold",   32'(imem_addr), 6);

    // call to 40, return to 3
    clear_rom();
    rom[2] = CALL; rom[40] = RET; rom[3] = HLT; tgt = 10'd40;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(40); exp_q.push_back(3);
    restart();
    wait_halt("b_halt", 40);
    chk("b_err", 32'(err), 0);
    chk("b_pc",  32'(imem_addr), 3);

    // five nested calls overflow the four-entry stack
    clear_rom();
    rom[0] = CALL; rom[40] = CALL;
    exp_q.push_back(0);
    for (int i = 0; i < 4; i++) exp_q.push_back(40);
    restart();
    wait_halt("c_halt", 40);
    chk("c_err_ovf", 32'(err), 1);
    chk("c_pc_hold", 32'(imem_addr), 40);

    // return with empty stack; restart clears the earlier error
    clear_rom();
    rom[0] = RET;
    exp_q.push_back(0);
    restart();
    chk("d_err_clr", 32'(err), 0);
    wait_halt("d_halt", 20);
    chk("d_err_unf", 32'(err), 2);
    chk("d_pc",      32'(imem_addr), 0);

    // load never acknowledged
    clear_rom();
    rom[0] = LD;
    exp_q.push_back(0);
    go_cnt = 0;
    restart();
    wait_halt("e_halt", 40);
    chk("e_go_cycles", 32'(go_cnt), MEM_TO);
    chk("e_err_tmo",   32'(err), 3);
    chk("e_go_low",    32'(mem_go), 0);

    // ack on the very last allowed cycle is accepted
    clear_rom();
    rom[0] = LD; rom[1] = HLT;
    exp_q.push_back(0); exp_q.push_back(1);
    go_cnt = 0;
    restart();
    wait_go("e2_go_seen", 20);
    repeat (MEM_TO - 1) tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    wait_halt("e2_halt", 20);
    chk("e2_go_cycles", 32'(go_cnt), MEM_TO);
    chk("e2_err",       32'(err), 0);
    chk("e2_pc",        32'(imem_addr), 1);

    // pc wraps at 1023; the call there pushes the wrapped 0
    clear_rom();
    rom[1] = JMAX; rom[1023] = CALL; rom[40] = RET; tgt = 10'd40;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1023);
    exp_q.push_back(40); exp_q.push_back(0);
    restart();
    wait_fetch("f_reach_max", 1023, 20);
    rom[0] = HLT;
    wait_halt("f_halt", 40);
    chk("f_pc_wrap", 32'(imem_addr), 0);
    chk("f_err",     32'(err), 0);

    // done at pc=7, start mid-run ignored, then restart from HALT
    clear_rom();
    rom[7] = HLT;
    for (int i = 0; i <= 7; i++) exp_q.push_back(i);
    restart();
    repeat (3) tick();
    restart();
    wait_halt("h_halt", 40);
    chk("h_pc", 32'(imem_addr), 7);
    for (int i = 0; i <= 7; i++) exp_q.push_back(i);
    restart();
    chk("h_restart_en",  32'(imem_en), 1);
    chk("h_restart_pc",  32'(imem_addr), 0);
    chk("h_restart_hlt", 32'(halted), 0);
    wait_halt("h_halt2", 40);

    // async reset in the middle of a memory wait
    clear_rom();
    rom[0] = LD;
    exp_q.push_back(0);
    restart();
    wait_go("i_go_seen", 20);
    tick();
    reset = 1'b1;
    #1;
    chk("i_go_drop",  32'(mem_go), 0);
    chk("i_run_drop", 32'(running), 0);
    chk("i_idle_hlt", 32'(halted), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rom[0] = HLT;
    exp_q.push_back(0);
    tick();
    restart();
    wait_halt("i_halt", 20);
    chk("i_pc", 32'(imem_addr), 0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
- Multi-cycle fetch/execute sequencer for the 9-bit CPU.
- Owns the program counter, instruction register, data-memory handshake and a small call/return stack.
- Feeds the latched instruction to the decoder and reacts to its done, load/store, branch, call and return indications.
- Sits between instruction ROM, decoder and data memory; one instruction in flight at a time.

Parameters:
PC_W, 10, program counter / instruction address width
STK_D, 4, call-stack depth (entries, each PC_W bits)
MEM_TO, 15, max cycles waiting for mem_ack before timeout error

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; forces all state to reset values immediately
start  in  1  level sampled in IDLE/HALT; begins execution at pc=0
instr_i  in  9  instruction ROM data, combinational read of imem_addr
imem_addr  out  PC_W  instruction fetch address (= pc)
imem_en  out  1  high only in FETCH
instr_q  out  9  latched instruction driven to decoder
done_i  in  1  decoder halt indication for instr_q
mem_req_i  in  1  decoder load or store request (loadEn|storEn)
mem_ack  in  1  data memory completion, one-cycle pulse
mem_go  out  1  data memory access strobe, held through MEMW
br_take  in  1  branch/jump resolved taken for instr_q
br_target  in  PC_W  destination for taken branch or call
call_i  in  1  subroutine call (decoder func op)
ret_i  in  1  subroutine return (decoder rFsr op)
running  out  1  high in FETCH, EXEC, MEMW
halted  out  1  high in HALT
err  out  2  sticky: 0 none, 1 stack overflow, 2 stack underflow, 3 memory timeout

Behaviour:
- States: IDLE, FETCH, EXEC, MEMW, HALT. Exactly one instruction is in flight at a time.
- Reset values:
  - State IDLE; pc=0; instr_q=9'h000; stack pointer 0; err=0.
  - Outputs: mem_go=0, imem_en=0, running=0, halted=0.
  - A timeout counter also resets to 0.
- IDLE: start=1 → FETCH with pc=0.
- FETCH (1 cycle): imem_en=1, imem_addr=pc. instr_q<=instr_i on exit → EXEC.
- EXEC (1 cycle): decoder outputs for instr_q are sampled. Priority is highest first:
  1. done_i → HALT; pc unchanged.
  2. mem_req_i → MEMW; mem_go=1 starting the next cycle.
  3. call_i:
     - Stack full (sp==STK_D): err=1, → HALT.
     - Otherwise push pc+1, sp+=1, pc=br_target, → FETCH.
  4. ret_i:
     - sp==0: err=2, → HALT.
     - Otherwise sp-=1, pc=popped entry, → FETCH.
  5. br_take → pc=br_target, → FETCH.
  6. Otherwise pc=pc+1, → FETCH.
- EXEC simultaneous events:
  - call_i and ret_i both high: call wins; ret ignored.
  - br_take with call_i: the call uses br_target; no separate branch.
- MEMW:
  - mem_go=1 every cycle in MEMW; the timeout counter increments each cycle.
  - mem_ack=1 → mem_go drops next cycle; pc=pc+1; → FETCH; counter cleared.
  - Counter reaches MEM_TO with no ack → err=3, mem_go=0, → HALT.
  - An ack arriving in the same cycle the counter reaches MEM_TO is accepted as success.
- HALT:
  - halted=1; pc, instr_q and err hold.
  - start=1 → clear err, sp=0, pc=0, → FETCH.
- Arithmetic and width:
  - pc+1 is modulo 2^PC_W; pc at all ones wraps to 0 without error.
  - Stack entries store the wrapped value.
- start while running (FETCH/EXEC/MEMW) is ignored.
- Latency:
  - Non-memory instruction: 2 cycles (FETCH+EXEC).
  - Memory instruction: 3 cycles + ack wait, minimum 3 when ack arrives the first MEMW cycle.
- Reset asserted mid-MEMW: mem_go drops asynchronously; no pending access is remembered.
- err is only cleared by reset or restart from HALT; it never changes while running.

Test Plan:
- Reset, start=1 one cycle, ROM holds non-branch ops at 0..3 → imem_addr sequence 0,1,2,3 on FETCH cycles two apart; running=1.
- Load op at pc=5, mem_ack 3 cycles after MEMW entry → mem_go high exactly 3 cycles, next FETCH at pc=6, err=0.
- Call at pc=2 (br_target=40), then ret at pc=40 → fetch 40, then 3; four nested calls then a fifth → err=1, halted=1, pc holds.
- ret with empty stack → err=2, HALT. MEMW with no ack → HALT after MEM_TO=15 cycles, err=3.
- pc=1023 non-branch with PC_W=10 → next fetch at 0. done_i at pc=7 → halted=1; start → FETCH pc=0, err=0.
- Reset asserted mid-MEMW → mem_go=0 and state IDLE within the same cycle; start afterwards fetches pc=0.
